// File: rtl/i2s_tx.sv
// I2S master transmitter: derives sck/ws from clk, buffers samples in a FIFO
// and shifts 32-bit slots out MSB-first in I2S or left-justified framing.
module i2s_tx #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    output logic          sck,
    output logic          ws,
    output logic          sdo,
    input  logic          en,
    input  logic          left_justified,
    input  logic [5:0]    sample_size,
    input  logic [7:0]    sck_prescaler,
    input  logic [1:0]    channels,
    input  logic          fifo_wr,
    input  logic [DW-1:0] fifo_wdata,
    input  logic          fifo_flush,
    input  logic [AW-1:0] fifo_level_threshold,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [AW-1:0] fifo_level,
    output logic          fifo_level_below,
    output logic          underflow,
    input  logic          underflow_clr
);

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    logic          sck_q, sck_d, ws_q, ws_d, sdo_q, sdo_d;
    logic [7:0]    presc_q, presc_d;
    logic [4:0]    p_q, p_d;
    logic          chan_q, chan_d;
    logic [31:0]   slot_q, slot_d;
    logic          lj_q, lj_d;
    logic          underflow_q, underflow_d;

    logic          tick, fallEvt, slotStart, chanNext, chanSel;
    logic          popReq, popOk, underflowSet, wrOk, ljEff, sdoNext;
    logic [4:0]    pNext;
    logic [5:0]    ssEff;
    logic [4:0]    shamt;
    logic [31:0]   newSlot;

    assign fifo_empty       = (count_q == '0);
    assign fifo_full        = count_q[AW];
    assign fifo_level       = count_q[AW-1:0];
    assign fifo_level_below = (fifo_level < fifo_level_threshold);

    assign sck       = sck_q;
    assign ws        = ws_q;
    assign sdo       = sdo_q;
    assign underflow = underflow_q;

    // A slot starts on the falling-edge event that wraps p from 31 back to 0.
    always_comb begin
        tick         = en && (presc_q == 8'd0);
        fallEvt      = tick && sck_q;
        pNext        = p_q + 5'd1;
        slotStart    = fallEvt && (p_q == 5'd31);
        chanNext     = ~chan_q;
        chanSel      = chanNext ? channels[0] : channels[1];
        popReq       = slotStart && chanSel && !fifo_flush;
        popOk        = popReq && !fifo_empty;
        underflowSet = popReq && fifo_empty;
        wrOk         = fifo_wr && !fifo_flush && (!fifo_full || popOk);
        ssEff        = ((sample_size == 6'd0) || (sample_size > 6'd32)) ? 6'd32 : sample_size;
        shamt        = 5'(6'd32 - ssEff);
        newSlot      = popOk ? (mem[rptr_q] << shamt) : 32'd0;
        ljEff        = slotStart ? left_justified : lj_q;
        if (ljEff) begin
            sdoNext = slotStart ? newSlot[31] : slot_q[~pNext];
        end else begin
            sdoNext = slotStart ? slot_q[0] : slot_q[5'd0 - pNext];
        end
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        if (fifo_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wrOk)  wptr_d = wptr_q + 1'b1;
            if (popOk) rptr_d = rptr_q + 1'b1;
            case ({wrOk, popOk})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        if (underflowSet)       underflow_d = 1'b1;
        else if (underflow_clr) underflow_d = 1'b0;
    end

    // Disabled transmitter is forced back to the idle frame position.
    always_comb begin
        sck_d   = sck_q;
        ws_d    = ws_q;
        sdo_d   = sdo_q;
        presc_d = presc_q;
        p_d     = p_q;
        chan_d  = chan_q;
        slot_d  = slot_q;
        lj_d    = lj_q;
        if (!en) begin
            sck_d   = 1'b0;
            ws_d    = 1'b1;
            sdo_d   = 1'b0;
            presc_d = 8'd0;
            p_d     = 5'd31;
            chan_d  = 1'b1;
            slot_d  = 32'd0;
        end else begin
            presc_d = tick ? sck_prescaler : presc_q - 8'd1;
            if (tick) sck_d = ~sck_q;
            if (fallEvt) begin
                p_d   = pNext;
                sdo_d = sdoNext;
            end
            if (slotStart) begin
                chan_d = chanNext;
                ws_d   = chanNext;
                slot_d = newSlot;
                lj_d   = left_justified;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q       <= 1'b0;
            ws_q        <= 1'b1;
            sdo_q       <= 1'b0;
            presc_q     <= 8'd0;
            p_q         <= 5'd31;
            chan_q      <= 1'b1;
            slot_q      <= 32'd0;
            lj_q        <= 1'b0;
            underflow_q <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            sck_q       <= sck_d;
            ws_q        <= ws_d;
            sdo_q       <= sdo_d;
            presc_q     <= presc_d;
            p_q         <= p_d;
            chan_q      <= chan_d;
            slot_q      <= slot_d;
            lj_q        <= lj_d;
            underflow_q <= underflow_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wrOk) mem[wptr_q] <= fifo_wdata;
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed testbench for i2s_tx: checks framing, FIFO behaviour, underflow
// handling and the idle/reset values of the serial outputs.
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck, ws, sdo;
    logic        en, left_justified;
    logic [5:0]  sample_size;
    logic [7:0]  sck_prescaler;
    logic [1:0]  channels;
    logic        fifo_wr;
    logic [31:0] fifo_wdata;
    logic        fifo_flush;
    logic [3:0]  fifo_level_threshold;
    logic        fifo_full, fifo_empty, fifo_level_below, underflow, underflow_clr;
    logic [3:0]  fifo_level;

    int errors = 0;
    int checks = 0;

    logic        sckPrev = 1'b0;
    int          cyc = 0;
    logic [1:0]  bitQ[$];
    int          timeQ[$];

    logic [128:0] sdoV, wsV, slotV, wsSlotV;
    int           tFirst, tSecond, tLast, tA, tB, tC;
    logic         seen;

    i2s_tx #(.AW(4), .DW(32)) dut (
        .clk(clk), .rst(rst), .sck(sck), .ws(ws), .sdo(sdo), .en(en),
        .left_justified(left_justified), .sample_size(sample_size),
        .sck_prescaler(sck_prescaler), .channels(channels),
        .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .fifo_flush(fifo_flush),
        .fifo_level_threshold(fifo_level_threshold), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .fifo_level(fifo_level),
        .fifo_level_below(fifo_level_below), .underflow(underflow),
        .underflow_clr(underflow_clr)
    );

    always #5 clk = ~clk;

    // Record ws/sdo right after every sck falling edge, sampled mid-cycle.
    always @(negedge clk) begin
        if (sckPrev && !sck) begin
            bitQ.push_back({ws, sdo});
            timeQ.push_back(cyc);
        end
        sckPrev = sck;
        cyc++;
    end

    task automatic checkOutput(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic writeWord(input logic [31:0] d);
        fifo_wr    = 1'b1;
        fifo_wdata = d;
        tick(1);
        fifo_wr    = 1'b0;
    endtask

    // Park the transmitter, empty the FIFO, clear underflow and set up framing.
    task automatic applyStimulus(input logic lj, input logic [5:0] ss, input logic [1:0] ch);
        en = 1'b0;
        tick(2);
        fifo_flush    = 1'b1;
        underflow_clr = 1'b1;
        tick(1);
        fifo_flush     = 1'b0;
        underflow_clr  = 1'b0;
        left_justified = lj;
        sample_size    = ss;
        channels       = ch;
        sck_prescaler  = 8'd1;
        bitQ.delete();
        timeQ.delete();
    endtask

    task automatic collect(input int n, output logic [128:0] dV, output logic [128:0] wV,
                           output int t0, output int t1, output int tn);
        int k = 0;
        dV = '0;
        wV = '0;
        t0 = 0;
        t1 = 0;
        tn = 0;
        while (bitQ.size() < n && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (bitQ.size() < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL collect timeout: got %0d bits required %0d", bitQ.size(), n);
            return;
        end
        t0 = timeQ[0];
        t1 = timeQ[1];
        tn = timeQ[n-1];
        for (int i = 0; i < n; i++) begin
            dV = {dV[127:0], bitQ[i][0]};
            wV = {wV[127:0], bitQ[i][1]};
        end
        repeat (n) begin
            void'(bitQ.pop_front());
            void'(timeQ.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        left_justified = 1'b1;
        sample_size = 6'd32;
        sck_prescaler = 8'd1;
        channels = 2'b11;
        fifo_wr = 1'b0;
        fifo_wdata = '0;
        fifo_flush = 1'b0;
        fifo_level_threshold = 4'd4;
        underflow_clr = 1'b0;
        tick(3);
        checkOutput("reset sck", sck, 1'b0);
        checkOutput("reset ws", ws, 1'b1);
        checkOutput("reset sdo", sdo, 1'b0);
        checkOutput("reset empty", fifo_empty, 1'b1);
        checkOutput("reset level", fifo_level, 4'd0);
        checkOutput("reset underflow", underflow, 1'b0);
        rst = 1'b0;
        tick(2);

        applyStimulus(1'b1, 6'd16, 2'b11);
        writeWord(32'h0000_00A5);
        writeWord(32'h0000_1234);
        en = 1'b1;
        collect(65, sdoV, wsV, tFirst, tSecond, tLast);
        checkOutput("lj16 sdo", sdoV, {32'h00A5_0000, 32'h1234_0000, 1'b0});
        checkOutput("lj16 ws", wsV, {32'h0, 32'hFFFF_FFFF, 1'b0});
        checkOutput("sck period", tSecond - tFirst, 4);
        checkOutput("frame length", tLast - tFirst, 256);
        checkOutput("lj16 underflow", underflow, 1'b1);

        applyStimulus(1'b0, 6'd16, 2'b11);
        writeWord(32'h0000_00A5);
        writeWord(32'h0000_1234);
        en = 1'b1;
        collect(65, sdoV, wsV, tFirst, tSecond, tLast);
        checkOutput("i2s16 sdo", sdoV, {1'b0, 32'h00A5_0000, 32'h1234_0000});
        checkOutput("i2s16 ws", wsV, {32'h0, 32'hFFFF_FFFF, 1'b0});
        checkOutput("i2s16 right first bit", sdoV[32], 1'b0);

        applyStimulus(1'b1, 6'd32, 2'b10);
        writeWord(32'h8000_0001);
        en = 1'b1;
        collect(65, sdoV, wsV, tFirst, tSecond, tLast);
        checkOutput("lj32 sdo", sdoV, {32'h8000_0001, 32'h0, 1'b0});
        checkOutput("lj32 msb first", sdoV[64], 1'b1);

        applyStimulus(1'b0, 6'd32, 2'b10);
        writeWord(32'h8000_0001);
        en = 1'b1;
        collect(65, sdoV, wsV, tFirst, tSecond, tLast);
        checkOutput("i2s32 sdo", sdoV, {1'b0, 32'h8000_0001, 32'h0});

        applyStimulus(1'b1, 6'd32, 2'b10);
        writeWord(32'h1111_1111);
        writeWord(32'h2222_2222);
        en = 1'b1;
        collect(128, sdoV, wsV, tFirst, tSecond, tLast);
        checkOutput("left only sdo", sdoV, {32'h1111_1111, 32'h0, 32'h2222_2222, 32'h0});
        checkOutput("left only empty", fifo_empty, 1'b1);
        checkOutput("left only no underflow", underflow, 1'b0);

        underflow_clr = 1'b1;
        seen = 1'b0;
        fork
            collect(32, slotV, wsSlotV, tA, tB, tC);
            begin
                repeat (200) begin
                    @(negedge clk);
                    if (underflow) seen = 1'b1;
                end
            end
        join
        checkOutput("underflow slot zero", slotV, 129'd0);
        checkOutput("underflow set wins", seen, 1'b1);
        underflow_clr = 1'b0;
        tick(1);
        checkOutput("underflow cleared", underflow, 1'b0);

        applyStimulus(1'b1, 6'd32, 2'b11);
        for (int i = 0; i < 16; i++) writeWord(32'h100 + i);
        checkOutput("full flag", fifo_full, 1'b1);
        checkOutput("full level wraps", fifo_level, 4'd0);
        writeWord(32'hDEAD_BEEF);
        checkOutput("write when full dropped", {fifo_full, fifo_level}, 5'b1_0000);
        fifo_flush = 1'b1;
        fifo_wr    = 1'b1;
        tick(1);
        fifo_flush = 1'b0;
        fifo_wr    = 1'b0;
        checkOutput("flush beats write", {fifo_empty, fifo_level}, 5'b1_0000);
        for (int i = 0; i < 3; i++) writeWord(32'h55);
        fifo_level_threshold = 4'd4;
        #1;
        checkOutput("level 3 below 4", {fifo_level, fifo_level_below}, 5'b0011_1);
        fifo_level_threshold = 4'd3;
        #1;
        checkOutput("level 3 below 3", fifo_level_below, 1'b0);

        applyStimulus(1'b1, 6'd32, 2'b11);
        writeWord(32'hFFFF_FFFF);
        writeWord(32'hFFFF_FFFF);
        writeWord(32'hFFFF_FFFF);
        en = 1'b1;
        tick(40);
        checkOutput("mid frame ws sdo", {ws, sdo}, 2'b01);
        en = 1'b0;
        tick(1);
        checkOutput("en drop idle", {sck, ws, sdo}, 3'b010);
        checkOutput("en drop keeps fifo", fifo_level, 4'd2);

        en = 1'b1;
        tick(40);
        checkOutput("second mid frame ws sdo", {ws, sdo}, 2'b01);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("async reset outputs", {sck, ws, sdo}, 3'b010);
        checkOutput("async reset fifo", {fifo_empty, fifo_level}, 5'b1_0000);
        en = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter; the transmit-direction counterpart of the team's I2S receiver.
- Generates sck/ws from the system clock, buffers host-written samples in an internal FIFO and serialises them MSB-first on sdo.
- Supports standard I2S (one-bit delay) and left-justified framing, with 32-bit slots and stereo or single-channel operation.
- Sits behind the bus wrapper, which drives the fifo_* and config ports.

Parameters:
AW, 4, FIFO address width; depth = 2^AW entries
DW, 32, FIFO data width (fixed 32)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
sck  out  1  serial clock
ws  out  1  word select (0 = left, 1 = right)
sdo  out  1  serial data
en  in  1  transmitter enable
left_justified  in  1  1 = LJ framing, 0 = I2S framing
sample_size  in  6  valid bits per sample, 1..32 (0 treated as 32)
sck_prescaler  in  8  sck half-period = sck_prescaler+1 clk cycles
channels  in  2  10 = left, 01 = right, 11 = stereo, 00 = mute
fifo_wr  in  1  write strobe
fifo_wdata  in  32  sample, right-aligned
fifo_flush  in  1  empty FIFO
fifo_level_threshold  in  AW  refill threshold
fifo_full  out  1  FIFO full
fifo_empty  out  1  FIFO empty
fifo_level  out  AW  entry count
fifo_level_below  out  1  fifo_level < fifo_level_threshold
underflow  out  1  sticky underflow flag
underflow_clr  in  1  clears underflow

Behaviour:
- Reset: sck=0, ws=1, sdo=0, underflow=0, FIFO empty, level=0, prescaler=0, bit position p=31, channel=right.
- While en=0, the same idle values are forced synchronously; FIFO contents and underflow are kept.
- Prescaler: when en=1, counts down from sck_prescaler. Each time it reaches 0, sck toggles and the prescaler reloads.
- Falling-edge event: the clk edge on which sck goes 1->0. On each event:
  - p = (p+1) mod 32.
  - When p wraps to 0, the channel toggles and ws = channel.
  - sck, ws and sdo are all registered and change on that same clk edge.
- First frame: the first event after en rises moves to p=0, channel left, ws=0.
- Slot word:
  - Captured on the event where p becomes 0.
  - Slot = head << (32 - sample_size); the low bits are zero-padded.
- FIFO pop:
  - Occurs at slot start only when the channel is selected by channels.
  - Unselected channels transmit a zero slot and do not pop.
  - channels=00 transmits zeros and never pops.
- sdo, LJ: sdo = slot[31-p].
- sdo, I2S: sdo = slot[32-p] for p >= 1. At p=0, sdo = bit 0 of the previous slot, which is 0 after idle.
- Underflow: a pop at slot start while fifo_empty=1 transmits a zero slot, sets underflow and leaves the pointers unchanged.
- underflow_clr: clears underflow. If a set event and underflow_clr occur in the same cycle, set wins.
- FIFO rules:
  - fifo_wr while full: write dropped.
  - Write and pop in the same cycle while empty: the pop sees empty, so underflow applies, and the write lands.
  - Write and pop in the same cycle while full: both occur and level is unchanged.
  - fifo_flush has priority over a write in the same cycle (write discarded); a pop in that cycle is suppressed.
  - Level wraps: when full, fifo_level reads 0 and fifo_full=1.
- Config changes take effect at the next slot start. sck_prescaler changes take effect at the next reload.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous).

Test Plan:
- sck_prescaler=1, LJ, sample_size=16, channels=11, write 0x00A5 then 0x1234, en=1:
  - sck period is 4 clk.
  - Left slot sdo = 0000000010100101 followed by 16 zeros, with ws=0.
  - Right slot sdo = 0001001000110100 followed by zeros, with ws=1.
  - Frame = 256 clk.
- Same stimulus with left_justified=0 -> identical bit stream delayed by one sck, and the first bit after each ws edge = 0.
- sample_size=32, write 0x80000001 -> MSB 1 immediately after the ws edge (LJ). The LSB 1 appears in bit 0 of the next slot in I2S mode.
- channels=10 with 2 entries written -> only left slots pop, right slots are all zero, and the FIFO is empty after 2 frames.
- FIFO empty at slot start -> zero slot and underflow=1. underflow_clr pulsed in the same cycle as a new underflow -> underflow stays 1.
- AW=4: write 17 entries -> 16 stored, fifo_full=1, fifo_level=0. fifo_flush with a simultaneous fifo_wr -> fifo_empty=1. en dropped mid-frame -> next clk sck=0, ws=1, sdo=0. rst mid-frame -> immediate reset values.
